// File: rtl/synth_audio_pkg.sv
// synth_audio_pkg: shared audio widths and I2S constants for the synthesizer output path.
package synth_audio_pkg;
  localparam int AUDIO_W = 16;
  localparam int SLOT_BITS_DEFAULT = 32;
  localparam logic LR_LEFT = 1'b0;
  localparam logic LR_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to BCLK and flags the clk cycle in which BCLK falls.
module i2s_bclk_gen #(
  parameter int BCLK_HALF_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk_o,
  output logic fall_evt_o
);
  localparam int DW = BCLK_HALF_DIV > 1 ? $clog2(BCLK_HALF_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic bclk_q, bclk_d, tc;
  always_comb begin
    tc = div_q == DW'(BCLK_HALF_DIV - 1);
    div_d = tc ? '0 : div_q + DW'(1);
    bclk_d = tc ? ~bclk_q : bclk_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bclk_q <= bclk_d;
    end
  end
  assign bclk_o = bclk_q;
  assign fall_evt_o = tc & bclk_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: serializes one mono sample per frame to both I2S channels with a
// single-entry valid/ready holding register in front of the active sample.
module i2s_dac_tx
  import synth_audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_W,
  parameter int SLOT_BITS = SLOT_BITS_DEFAULT,
  parameter int BCLK_HALF_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  bclk,
  output logic                  lrck,
  output logic                  dacdat
);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [BW-1:0] LAST = BW'(2 * SLOT_BITS - 1);
  logic [BW-1:0] bit_q, bit_d, p;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, act_q, act_d, sh;
  logic lrck_q, lrck_d, dat_q, dat_d, fs_q, fs_d, ur_q, ur_d, full_q, full_d;
  logic fall, load, accept;
  i2s_bclk_gen #(.BCLK_HALF_DIV(BCLK_HALF_DIV)) u_bclk (
    .clk(clk),
    .reset_n(reset_n),
    .bclk_o(bclk),
    .fall_evt_o(fall)
  );
  // Load decision uses pre-edge full_q, so an accept on the load edge waits a frame.
  always_comb begin
    bit_d = fall ? (bit_q == LAST ? '0 : bit_q + BW'(1)) : bit_q;
    load = fall && bit_d == '0;
    accept = sample_valid && !full_q;
    act_d = load && full_q ? hold_q : act_q;
    hold_d = accept ? sample_in : hold_q;
    full_d = accept ? 1'b1 : (load ? 1'b0 : full_q);
    p = bit_d >= BW'(SLOT_BITS) ? bit_d - BW'(SLOT_BITS) : bit_d;
    sh = act_d << (p - BW'(1));
    dat_d = fall ? (p != '0 && p <= BW'(DATA_WIDTH) && sh[DATA_WIDTH-1]) : dat_q;
    lrck_d = fall && bit_d == '0 ? LR_LEFT : (fall && bit_d == BW'(SLOT_BITS) ? LR_RIGHT : lrck_q);
    fs_d = load;
    ur_d = load && !full_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_q <= LAST;
      lrck_q <= LR_RIGHT;
      dat_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      full_q <= 1'b0;
      hold_q <= '0;
      act_q <= '0;
    end else begin
      bit_q <= bit_d;
      lrck_q <= lrck_d;
      dat_q <= dat_d;
      fs_q <= fs_d;
      ur_q <= ur_d;
      full_q <= full_d;
      hold_q <= hold_d;
      act_q <= act_d;
    end
  end
  assign sample_ready = !full_q;
  assign frame_start = fs_q;
  assign underrun = ur_q;
  assign lrck = lrck_q;
  assign dacdat = dat_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed checks of the I2S framing, data bits and handshake corner cases.
module tb_i2s_dac_tx;
  logic clk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic sample_ready, frame_start, underrun, bclk, lrck, dacdat;
  int passed = 0, total = 0;
  logic [31:0] l, r;
  logic [63:0] lr;
  localparam logic [63:0] LR_EXP = {32'h0, 32'hFFFF_FFFF};
  i2s_dac_tx dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .frame_start(frame_start), .underrun(underrun),
    .bclk(bclk), .lrck(lrck), .dacdat(dacdat)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Samples dacdat/lrck at each BCLK rise over one frame, starting just after a load edge.
  task automatic cap(input int pre, input int post, output logic [31:0] lo, output logic [31:0] ro,
                     output logic [63:0] lro);
    logic [63:0] d;
    for (int i = 0; i < 64; i++) begin
      tick(i == 0 ? 8 - pre : 8);
      d[63-i] = dacdat;
      lro[63-i] = lrck;
      tick(i == 63 ? 8 - post : 8);
    end
    lo = d[63:32];
    ro = d[31:0];
  endtask
  task automatic chk_frame(input string tag, input logic [15:0] s);
    chk({tag, "_left"}, l, {1'b0, s, 15'b0});
    chk({tag, "_right"}, r, {1'b0, s, 15'b0});
    chk({tag, "_lrck"}, lr, LR_EXP);
  endtask
  task automatic chk_startup(input string tag);
    tick(7);
    chk({tag, "_bclk_pre_rise"}, bclk, 1'b0);
    tick(1);
    chk({tag, "_bclk_rise8"}, bclk, 1'b1);
    tick(7);
    chk({tag, "_fs_before16"}, frame_start, 1'b0);
    tick(1);
    chk({tag, "_bclk_fall16"}, bclk, 1'b0);
    chk({tag, "_lrck16"}, lrck, 1'b0);
    chk({tag, "_fs16"}, frame_start, 1'b1);
    chk({tag, "_ur16"}, underrun, 1'b1);
    chk({tag, "_dat16"}, dacdat, 1'b0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bclk"}, bclk, 1'b0);
    chk({tag, "_lrck"}, lrck, 1'b1);
    chk({tag, "_dat"}, dacdat, 1'b0);
    chk({tag, "_ready"}, sample_ready, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_ur"}, underrun, 1'b0);
  endtask
  initial begin
    tick(3);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    chk_startup("boot");
    // Frame 1 plays zero; push 0xA5F0 one clk into it.
    sample_in = 16'hA5F0;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    chk("push_ready_low", sample_ready, 1'b0);
    chk("fs_one_clk", frame_start, 1'b0);
    cap(1, 0, l, r, lr);
    chk_frame("f1_zero", 16'h0000);
    chk("f2_fs_1024", frame_start, 1'b1);
    chk("f2_no_ur", underrun, 1'b0);
    chk("f2_ready_back", sample_ready, 1'b1);
    cap(0, 0, l, r, lr);
    chk_frame("f2_a5f0", 16'hA5F0);
    chk("f3_ur", underrun, 1'b1);
    // Frame 3 repeats 0xA5F0; push 0x8000 then hold 0x7FFF valid across the stall.
    sample_in = 16'h8000;
    sample_valid = 1'b1;
    tick(1);
    sample_in = 16'h7FFF;
    chk("b2b_ready_low", sample_ready, 1'b0);
    cap(1, 0, l, r, lr);
    chk_frame("f3_repeat", 16'hA5F0);
    chk("f4_fs", frame_start, 1'b1);
    chk("f4_no_ur", underrun, 1'b0);
    chk("f4_ready_at_load", sample_ready, 1'b1);
    tick(1);
    sample_valid = 1'b0;
    chk("f4_7fff_taken", sample_ready, 1'b0);
    cap(1, 0, l, r, lr);
    chk_frame("f4_8000", 16'h8000);
    chk("f5_no_ur", underrun, 1'b0);
    cap(0, 1, l, r, lr);
    chk_frame("f5_7fff", 16'h7FFF);
    // 0x1234 presented so that it is accepted on the frame 6 load edge itself.
    sample_in = 16'h1234;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    chk("f6_fs", frame_start, 1'b1);
    chk("f6_ur_on_accept", underrun, 1'b1);
    chk("f6_accepted", sample_ready, 1'b0);
    cap(0, 0, l, r, lr);
    chk_frame("f6_old", 16'h7FFF);
    chk("f7_no_ur", underrun, 1'b0);
    cap(0, 0, l, r, lr);
    chk_frame("f7_1234", 16'h1234);
    // Mid-left-slot async reset while bclk=1 and dacdat=1 (p=4 of 0x1234).
    tick(75);
    chk("mid_bclk_high", bclk, 1'b1);
    chk("mid_dat_high", dacdat, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    tick(2);
    reset_n = 1'b1;
    chk_startup("restart");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Downstream of the synthesizer core. Takes the 16-bit mono sample the core produces each audio frame and serializes it to the on-board audio codec DAC in Philips I2S format.
- The same sample goes out on both left and right channels.
- Generates BCLK and LRCK from the system clock.
- Tells the producer when a new sample is needed through a valid/ready handshake and a per-frame strobe.

Parameters:
- DATA_WIDTH, 16: sample width in bits; matches the synthesizer output bus.
- SLOT_BITS, 32: BCLK periods per channel slot; legal range is ≥ DATA_WIDTH+1.
- BCLK_HALF_DIV, 8: clk cycles per BCLK half-period; legal range is ≥ 1. At 50 MHz this gives BCLK = 3.125 MHz and fs = 48.83 kHz.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- sample_in  in  DATA_WIDTH  two's-complement audio sample.
- sample_valid  in  1  sample_in is presented.
- sample_ready  out  1  holding register is empty; a transfer occurs when valid & ready on a clk edge.
- frame_start  out  1  one-clk pulse when a new frame begins; the producer should compute its next sample.
- underrun  out  1  one-clk pulse when a frame starts with no new sample held.
- bclk  out  1  I2S bit clock.
- lrck  out  1  I2S word select: 0 = left, 1 = right.
- dacdat  out  1  I2S serial data.

Behaviour:
- Reset is asynchronous and active-low. Everything clears immediately on assertion, including mid-frame. Reset values:
  - bclk=0, lrck=1, dacdat=0
  - sample_ready=1, frame_start=0, underrun=0
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1
  - holding register empty; active sample=0
- BCLK divider:
  - div_cnt counts 0..BCLK_HALF_DIV-1.
  - At terminal count: bclk toggles and div_cnt wraps to 0.
  - A "fall event" is the clk cycle in which bclk goes 1→0.
  - First rise is at clk 8 after reset release; first fall at clk 16 (defaults).
- Per fall event:
  - bit_cnt increments modulo 2*SLOT_BITS.
  - lrck, dacdat and the frame logic update in that same clk edge, so the codec samples them on the next BCLK rise.
- Word select:
  - lrck <= 0 when the new bit_cnt = 0.
  - lrck <= 1 when the new bit_cnt = SLOT_BITS.
- Data, I2S one-bit delay:
  - Slot position p = bit_cnt mod SLOT_BITS.
  - For p in 1..DATA_WIDTH: dacdat <= active[DATA_WIDTH-p], MSB first.
  - For p = 0 and p > DATA_WIDTH: dacdat <= 0.
  - The right slot repeats the same active sample.
- Frame load, on the fall event where the new bit_cnt = 0:
  - frame_start pulses for 1 clk.
  - If the holding register is full: active <= holding, holding is emptied, and dacdat takes active's new MSB at p=1.
  - If the holding register is empty: active is unchanged (last sample repeats) and underrun pulses for 1 clk.
  - The first frame after reset always raises underrun and plays 0.
- Handshake:
  - sample_ready = !holding_full, registered.
  - Accept when sample_valid & sample_ready: holding <= sample_in, full<=1, ready drops the next cycle.
  - At most one sample is buffered. When ready=0, valid is ignored and the producer must hold it.
- Simultaneous accept and frame load in the same clk, with holding empty before the edge:
  - The load decision uses the pre-edge holding state, so underrun pulses and active is unchanged.
  - The accepted sample stays in holding for the next frame.
- Simultaneous load and accept with holding full:
  - Not possible, because ready=0.
- Latency:
  - A sample accepted at least one clk before a frame's load edge is transmitted in that frame.
  - Its MSB is on dacdat from the load edge.
- sample_in is not inspected, so any value (0x8000, 0x7FFF) passes bit-exact.

Decomposition:
- synth_audio_pkg:
  - AUDIO_W=16 (shared with the synthesizer output width)
  - SLOT_BITS_DEFAULT=32
  - LR_LEFT=1'b0, LR_RIGHT=1'b1
- Sub-module i2s_bclk_gen (~50 lines): div_cnt plus bclk toggle, producing bclk and a fall_evt strobe.
- The top holds bit_cnt, lrck, the shifter/mux, the holding register and the handshake.

Test Plan:
- Reset release, no samples:
  - bclk rises at clk 8 and falls at clk 16.
  - At clk 16: lrck 1→0, frame_start=1, underrun=1, dacdat=0 for the whole frame.
  - The next frame_start is 1024 clks later.
- Push 0xA5F0 before frame 2:
  - sample_ready drops for one frame.
  - dacdat captured at BCLK rises, left slot p=1..16 = 1010_0101_1111_0000; p=0 and p=17..31 = 0.
  - The right slot is identical; lrck rises at p=32.
- No push before frame 3:
  - underrun pulses and 0xA5F0 is retransmitted unchanged.
- Back-to-back pushes 0x8000 then 0x7FFF:
  - The second transfer stalls with ready=0 until the frame_start edge, and is accepted 1 clk later.
  - The frames carry 0x8000 then 0x7FFF bit-exact.
- Valid asserted exactly on the load clk with holding empty, value 0x1234:
  - underrun=1 and the old sample plays.
  - 0x1234 appears in the following frame.
- reset_n pulsed low mid-left-slot:
  - All outputs take reset values asynchronously.
  - The frame sequence restarts as in the first test.
